// File: rtl/router_pkg.sv
// router_pkg
//   Shared definitions for the packet router: command encodings, the FSM
//   state type and the layout of the status word.
//
//   Status word layout, LSB first:
//     [CNT_W-1:0]        packet_count
//     [2*CNT_W-1:CNT_W]  error_count
//   The word is zero-extended or truncated to DATA_W.
package router_pkg;

  localparam int CMD_LOOPBACK  = 0;
  localparam int CMD_SLM_WRITE = 1;
  localparam int CMD_STATUS    = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_FWD,
    ST_DRAIN,
    ST_STATUS
  } state_t;

endpackage

// File: rtl/router_out_reg.sv
// router_out_reg
//   One-entry valid/ready output register. A load captures i_data and raises
//   o_valid. o_valid then holds, together with o_word, until a handshake.
//   o_word keeps its last value after the handshake.
//
// Ports
//   i_clock    system clock
//   i_reset    asynchronous reset, active-low
//   i_load     capture i_data this cycle (only when o_load_ok is high)
//   i_data     word to capture
//   i_ready    downstream accepts o_word this cycle
//   o_valid    o_word is valid
//   o_word     registered output word
//   o_load_ok  register is empty or is being emptied this cycle
module router_out_reg #(
  parameter int W = 32
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_word,
  output logic         o_load_ok
);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_valid <= 1'b0;
      o_word  <= '0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_word  <= i_data;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

  assign o_load_ok = !o_valid || i_ready;

endmodule

// File: rtl/packet_router.sv
// packet_router
//   Reads a length word and N payload words from the show-ahead RX FIFO for
//   each decoded packet. Payload goes to PC_TX (loopback) or SLM_CONFIG
//   (slm write). Bad or oversize packets are drained and counted. Status
//   requests answer with one TX word {error_count, packet_count}.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for i_packet_fully_decoded
//   ST_LEN    | waiting for and popping the length word
//   ST_FWD    | moving payload words into the selected output register
//   ST_DRAIN  | popping and discarding payload (bad/oversize/status body)
//   ST_STATUS | presenting the status word on TX until accepted
//
// Ports
//   i_clock, i_reset (async, active-low)
//   i_packet_command, i_packet_fully_decoded      packet header from decoder
//   i_rx_fifo_output_word, i_rx_fifo_is_empty_sig RX FIFO head and empty flag
//   o_rx_fifo_next_word_cmd                       FIFO pop strobe
//   o_tx_word, o_tx_valid, i_tx_ready             PC_TX channel
//   o_slm_word, o_slm_valid, i_slm_ready          SLM_CONFIG channel
//   o_busy                                        FSM not in ST_IDLE
//   o_error_count                                 bad/oversize packet count
module packet_router
  import router_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int CMD_W     = 2,
  parameter int LEN_W     = 16,
  parameter int MAX_WORDS = 1024,
  parameter int CNT_W     = 16
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [CMD_W-1:0]  i_packet_command,
  input  logic              i_packet_fully_decoded,
  input  logic [DATA_W-1:0] i_rx_fifo_output_word,
  input  logic              i_rx_fifo_is_empty_sig,
  output logic              o_rx_fifo_next_word_cmd,
  output logic [DATA_W-1:0] o_tx_word,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic [DATA_W-1:0] o_slm_word,
  output logic              o_slm_valid,
  input  logic              i_slm_ready,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_error_count
);

  localparam int REM_W = LEN_W + 1;

  state_t             state;
  logic [CMD_W-1:0]   cmd_q;
  logic [REM_W-1:0]   remaining;
  logic [CNT_W-1:0]   packet_count;
  logic [CNT_W-1:0]   error_count;
  logic               status_pend;

  logic [LEN_W-1:0]   len_n;
  logic [REM_W-1:0]   len_ext;
  logic               oversize;
  logic               is_tx;
  logic               is_slm;
  logic               is_status;
  logic               is_reserved;
  logic               rem_zero;

  logic               tx_load;
  logic               tx_load_ok;
  logic [DATA_W-1:0]  tx_data;
  logic               slm_load;
  logic               slm_load_ok;
  logic               sel_load_ok;
  logic               pop;
  logic [DATA_W-1:0]  status_word;

  assign len_n       = i_rx_fifo_output_word[LEN_W-1:0];
  assign len_ext     = {1'b0, len_n};
  assign oversize    = len_ext > REM_W'(MAX_WORDS);
  assign is_tx       = cmd_q == CMD_W'(CMD_LOOPBACK);
  assign is_slm      = cmd_q == CMD_W'(CMD_SLM_WRITE);
  assign is_status   = cmd_q == CMD_W'(CMD_STATUS);
  assign is_reserved = !(is_tx || is_slm || is_status);
  assign rem_zero    = remaining == '0;
  assign sel_load_ok = is_tx ? tx_load_ok : slm_load_ok;
  assign status_word = DATA_W'({error_count, packet_count});

  // The pop is decoded combinationally so the show-ahead head word is
  // captured by the output register on the same edge that pops it; this is
  // what allows one word per clock through FWD.
  always_comb begin
    pop = 1'b0;
    case (state)
      ST_LEN:   pop = !i_rx_fifo_is_empty_sig;
      ST_FWD:   pop = !i_rx_fifo_is_empty_sig && !rem_zero && sel_load_ok;
      ST_DRAIN: pop = !i_rx_fifo_is_empty_sig && !rem_zero;
      default:  pop = 1'b0;
    endcase
  end

  // The TX register is always empty when STATUS is entered (FWD only exits
  // after its last word is accepted), so the status load needs no load_ok.
  assign tx_load  = (state == ST_FWD && pop && is_tx) ||
                    (state == ST_STATUS && status_pend);
  assign tx_data  = (state == ST_STATUS) ? status_word : i_rx_fifo_output_word;
  assign slm_load = state == ST_FWD && pop && is_slm;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state        <= ST_IDLE;
      cmd_q        <= '0;
      remaining    <= '0;
      packet_count <= '0;
      error_count  <= '0;
      status_pend  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_packet_fully_decoded) begin
            cmd_q <= i_packet_command;
            state <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (!i_rx_fifo_is_empty_sig) begin
            if (len_n == '0) begin
              if (is_status) begin
                status_pend <= 1'b1;
                state       <= ST_STATUS;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              remaining <= len_ext;
              if (oversize || is_reserved) begin
                error_count <= error_count + CNT_W'(1);
                state       <= ST_DRAIN;
              end else if (is_status) begin
                state <= ST_DRAIN;
              end else begin
                state <= ST_FWD;
              end
            end
          end
        end
        ST_FWD: begin
          if (pop) begin
            remaining <= remaining - REM_W'(1);
          end else if (rem_zero && sel_load_ok) begin
            // last word already gone or handshaking this cycle
            packet_count <= packet_count + CNT_W'(1);
            state        <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (pop) begin
            remaining <= remaining - REM_W'(1);
          end else if (rem_zero) begin
            if (is_status) begin
              status_pend <= 1'b1;
              state       <= ST_STATUS;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_STATUS: begin
          if (status_pend) begin
            status_pend <= 1'b0;
          end else if (o_tx_valid && i_tx_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  router_out_reg #(.W(DATA_W)) u_tx_reg (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_load    (tx_load),
    .i_data    (tx_data),
    .i_ready   (i_tx_ready),
    .o_valid   (o_tx_valid),
    .o_word    (o_tx_word),
    .o_load_ok (tx_load_ok)
  );

  router_out_reg #(.W(DATA_W)) u_slm_reg (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_load    (slm_load),
    .i_data    (i_rx_fifo_output_word),
    .i_ready   (i_slm_ready),
    .o_valid   (o_slm_valid),
    .o_word    (o_slm_word),
    .o_load_ok (slm_load_ok)
  );

  assign o_rx_fifo_next_word_cmd = pop;
  assign o_busy                  = state != ST_IDLE;
  assign o_error_count           = error_count;

endmodule
